// File: rtl/seg7_scan_capture_pkg.sv
// rtl/seg7_scan_capture_pkg.sv - shared segment codes, FSM states and strobe helpers for the 7-seg capture path
package seg7_scan_capture_pkg;

  // Active-low segment codes, bit0=A .. bit6=G
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } state_t;

  typedef struct packed {
    logic       invalid;
    logic       blank;
    logic       dp;
    logic [3:0] nibble;
  } digit_t;

  function automatic logic strobe_valid(input logic [3:0] s);
    case (s)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] strobe_idx(input logic [3:0] s);
    case (s)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational active-low 7-segment pattern to BCD nibble decoder
module seg7_pattern_decode
  import seg7_scan_capture_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       invalid
);

  always_comb begin
    nibble  = 4'h0;
    blank   = 1'b0;
    invalid = 1'b0;
    case (pattern)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_BLANK: blank  = 1'b1;
      default: begin
        invalid = 1'b1;
        nibble  = 4'hF;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// rtl/seg7_scan_capture.sv - samples a multiplexed 4-digit 7-seg bus and publishes decoded frames
module seg7_scan_capture
  import seg7_scan_capture_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  digits_in,
  input  logic [7:0]  segments_in,
  output logic [15:0] value,
  output logic [3:0]  blank,
  output logic [3:0]  invalid,
  output logic [3:0]  dp,
  output logic        frame_valid,
  output logic        stale
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [3:0]  dig_s1_q, dig_s2_q, dig_prev_q;
  logic [7:0]  seg_s1_q, seg_s2_q, seg_prev_q;

  state_t      state_q, state_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [TW-1:0] timeout_cnt_q, timeout_cnt_d;
  logic [3:0]  seen_q, seen_d;
  digit_t [3:0] shadow_q, shadow_d;

  logic [15:0] value_q, value_d;
  logic [3:0]  blank_q, blank_d;
  logic [3:0]  invalid_q, invalid_d;
  logic [3:0]  dp_q, dp_d;
  logic        frame_valid_q, frame_valid_d;
  logic        stale_q, stale_d;

  logic        strobe_ok, same, sample, frame_fire;
  logic [1:0]  idx;
  logic [3:0]  dec_nibble;
  logic        dec_blank, dec_invalid;

  seg7_pattern_decode u_decode (
    .pattern (seg_s2_q[6:0]),
    .nibble  (dec_nibble),
    .blank   (dec_blank),
    .invalid (dec_invalid)
  );

  // Synchronisers idle at the "nothing driven" level so reset looks like an invalid strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_s1_q   <= 4'hF;
      dig_s2_q   <= 4'hF;
      dig_prev_q <= 4'hF;
      seg_s1_q   <= 8'hFF;
      seg_s2_q   <= 8'hFF;
      seg_prev_q <= 8'hFF;
    end else begin
      dig_s1_q   <= digits_in;
      dig_s2_q   <= dig_s1_q;
      dig_prev_q <= dig_s2_q;
      seg_s1_q   <= segments_in;
      seg_s2_q   <= seg_s1_q;
      seg_prev_q <= seg_s2_q;
    end
  end

  always_comb begin
    strobe_ok    = strobe_valid(dig_s2_q);
    same         = (dig_s2_q == dig_prev_q) && (seg_s2_q == seg_prev_q);
    idx          = strobe_idx(dig_s2_q);
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    sample       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (strobe_ok) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
        end
      end
      ST_SETTLE: begin
        if (!strobe_ok) begin
          state_d      = ST_IDLE;
          settle_cnt_d = '0;
        end else if (!same) begin
          settle_cnt_d = '0;
        end else if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
          sample       = 1'b1;
          state_d      = ST_HELD;
          settle_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (!strobe_ok) begin
          state_d = ST_IDLE;
        end else if (!same) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        settle_cnt_d = '0;
      end
    endcase
  end

  // A sample landing on the frame cycle sets its bit after the clear
  always_comb begin
    frame_fire = (seen_q == 4'hF);
    shadow_d   = shadow_q;
    seen_d     = frame_fire ? 4'h0 : seen_q;
    if (sample) begin
      shadow_d[idx].nibble  = dec_nibble;
      shadow_d[idx].blank   = dec_blank;
      shadow_d[idx].invalid = dec_invalid;
      shadow_d[idx].dp      = ~seg_s2_q[7];
      seen_d[idx]           = 1'b1;
    end
  end

  always_comb begin
    value_d       = value_q;
    blank_d       = blank_q;
    invalid_d     = invalid_q;
    dp_d          = dp_q;
    frame_valid_d = frame_fire;
    if (frame_fire) begin
      for (int i = 0; i < 4; i++) begin
        value_d[4*i +: 4] = shadow_q[i].nibble;
        blank_d[i]        = shadow_q[i].blank;
        invalid_d[i]      = shadow_q[i].invalid;
        dp_d[i]           = shadow_q[i].dp;
      end
    end
  end

  // stale also holds from reset until the first frame, since the counter starts at zero
  always_comb begin
    timeout_cnt_d = timeout_cnt_q;
    stale_d       = stale_q;
    if (frame_fire) begin
      timeout_cnt_d = '0;
      stale_d       = 1'b0;
    end else begin
      if (timeout_cnt_q != TW'(TIMEOUT_CYCLES))
        timeout_cnt_d = timeout_cnt_q + 1'b1;
      stale_d = stale_q | (timeout_cnt_d == TW'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      settle_cnt_q  <= '0;
      timeout_cnt_q <= '0;
      seen_q        <= 4'h0;
      shadow_q      <= '0;
      value_q       <= 16'h0000;
      blank_q       <= 4'hF;
      invalid_q     <= 4'h0;
      dp_q          <= 4'h0;
      frame_valid_q <= 1'b0;
      stale_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      seen_q        <= seen_d;
      shadow_q      <= shadow_d;
      value_q       <= value_d;
      blank_q       <= blank_d;
      invalid_q     <= invalid_d;
      dp_q          <= dp_d;
      frame_valid_q <= frame_valid_d;
      stale_q       <= stale_d;
    end
  end

  assign value       = value_q;
  assign blank       = blank_q;
  assign invalid     = invalid_q;
  assign dp          = dp_q;
  assign frame_valid = frame_valid_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb/tb_seg7_scan_capture.sv - directed self-checking bench for seg7_scan_capture
module tb_seg7_scan_capture;

  localparam logic [7:0] P1 = 8'hF9;
  localparam logic [7:0] P2 = 8'hA4;
  localparam logic [7:0] P3 = 8'hB0;
  localparam logic [7:0] P4 = 8'h99;
  localparam logic [7:0] P6 = 8'h82;
  localparam logic [7:0] P8 = 8'h80;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  digits_in;
  logic [7:0]  segments_in;
  logic [15:0] value;
  logic [3:0]  blank, invalid, dp;
  logic        frame_valid, stale;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int fv_count = 0;
  int fv_cyc   = 0;
  logic fv_stale = 1'b1;

  seg7_scan_capture #(.SETTLE_CYCLES(16), .TIMEOUT_CYCLES(1000)) dut (
    .clk         (clk),
    .rst         (rst),
    .digits_in   (digits_in),
    .segments_in (segments_in),
    .value       (value),
    .blank       (blank),
    .invalid     (invalid),
    .dp          (dp),
    .frame_valid (frame_valid),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      fv_count <= fv_count + 1;
      fv_cyc   <= cyc;
      fv_stale <= stale;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  // Called at posedge+1; returns at posedge+1 after n cycles
  task automatic drive(input int idx, input logic [7:0] seg, input int n);
    digits_in   = ~(4'b0001 << idx);
    segments_in = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [7:0] s0, input logic [7:0] s1,
                      input logic [7:0] s2, input logic [7:0] s3, input int n);
    drive(0, s0, n);
    drive(1, s1, n);
    drive(2, s2, n);
    drive(3, s3, n);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    digits_in = 4'hF;
    segments_in = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (value !== 16'h0000) begin errors++; $display("FAIL reset.value got %h exp 0000", value); end
    vectors++; if (blank !== 4'hF) begin errors++; $display("FAIL reset.blank got %h exp F", blank); end
    vectors++; if (invalid !== 4'h0 || dp !== 4'h0) begin errors++; $display("FAIL reset.invalid_dp got %h/%h exp 0/0", invalid, dp); end
    vectors++; if (frame_valid !== 1'b0 || stale !== 1'b1) begin errors++; $display("FAIL reset.fv_stale got %b/%b exp 0/1", frame_valid, stale); end
    rst = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    vectors++; if (fv_count !== 0) begin errors++; $display("FAIL reset.idle_frames got %0d exp 0", fv_count); end
    vectors++; if (stale !== 1'b1) begin errors++; $display("FAIL reset.idle_stale got %b exp 1", stale); end
    @(posedge clk); #1;
  endtask

  task automatic test_scan;
    int n0, c;
    n0 = fv_count;
    scan(P3, P6, P3, P3, 100);
    @(negedge clk);
    vectors++; if (fv_count - n0 !== 1) begin errors++; $display("FAIL scan.frames got %0d exp 1", fv_count - n0); end
    vectors++; if (value !== 16'h3363) begin errors++; $display("FAIL scan.value got %h exp 3363", value); end
    vectors++; if (blank !== 4'h0 || invalid !== 4'h0 || dp !== 4'h0) begin errors++; $display("FAIL scan.flags got %h/%h/%h exp 0/0/0", blank, invalid, dp); end
    vectors++; if (stale !== 1'b0) begin errors++; $display("FAIL scan.stale got %b exp 0", stale); end
    @(posedge clk); #1;
    drive(0, P3, 100);
    drive(1, P6, 100);
    drive(2, P3, 100);
    c = cyc;
    drive(3, P3, 100);
    @(negedge clk);
    vectors++; if (fv_count - n0 !== 2) begin errors++; $display("FAIL scan.second_frame got %0d exp 2", fv_count - n0); end
    vectors++; if (fv_cyc !== c + 20) begin errors++; $display("FAIL scan.latency got %0d exp %0d", fv_cyc - c - 1, 19); end
    @(posedge clk); #1;
  endtask

  task automatic test_blank_invalid;
    int n0;
    n0 = fv_count;
    scan(8'h30, 8'hFF, P3, 8'hAA, 100);
    @(negedge clk);
    vectors++; if (fv_count - n0 !== 1) begin errors++; $display("FAIL blank_inv.frames got %0d exp 1", fv_count - n0); end
    vectors++; if (value !== 16'hF303) begin errors++; $display("FAIL blank_inv.value got %h exp F303", value); end
    vectors++; if (blank !== 4'b0010) begin errors++; $display("FAIL blank_inv.blank got %b exp 0010", blank); end
    vectors++; if (invalid !== 4'b1000) begin errors++; $display("FAIL blank_inv.invalid got %b exp 1000", invalid); end
    vectors++; if (dp !== 4'b0001) begin errors++; $display("FAIL blank_inv.dp got %b exp 0001", dp); end
    @(posedge clk); #1;
  endtask

  task automatic test_glitch;
    int n0;
    logic [7:0] pat [4];
    pat[0] = P3; pat[1] = P6; pat[2] = P3; pat[3] = P3;
    n0 = fv_count;
    for (int i = 0; i < 4; i++) begin
      drive(i, P8, 10);
      drive(i, pat[i], 90);
    end
    @(negedge clk);
    vectors++; if (fv_count - n0 !== 1) begin errors++; $display("FAIL glitch.frames got %0d exp 1", fv_count - n0); end
    vectors++; if (value !== 16'h3363) begin errors++; $display("FAIL glitch.value got %h exp 3363", value); end
    vectors++; if (blank !== 4'h0 || invalid !== 4'h0) begin errors++; $display("FAIL glitch.flags got %h/%h exp 0/0", blank, invalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_strobe_fault;
    int n0;
    n0 = fv_count;
    digits_in = 4'b0011;
    segments_in = P8;
    repeat (50) @(posedge clk);
    #1;
    drive(3, P4, 100);
    drive(1, P2, 100);
    drive(0, P1, 100);
    @(negedge clk);
    vectors++; if (fv_count !== n0) begin errors++; $display("FAIL fault.early_frame got %0d exp 0", fv_count - n0); end
    @(posedge clk); #1;
    drive(2, P3, 100);
    @(negedge clk);
    vectors++; if (fv_count - n0 !== 1) begin errors++; $display("FAIL fault.frames got %0d exp 1", fv_count - n0); end
    vectors++; if (value !== 16'h4321) begin errors++; $display("FAIL fault.value got %h exp 4321", value); end
    vectors++; if (blank !== 4'h0 || invalid !== 4'h0 || dp !== 4'h0) begin errors++; $display("FAIL fault.flags got %h/%h/%h exp 0/0/0", blank, invalid, dp); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout;
    int n0, t_rise;
    bit rose;
    n0 = fv_count;
    digits_in = 4'hF;
    segments_in = 8'hFF;
    rose = 1'b0;
    t_rise = 0;
    @(negedge clk);
    vectors++; if (stale !== 1'b0) begin errors++; $display("FAIL timeout.early_stale got %b exp 0", stale); end
    for (int i = 0; i < 1200 && !rose; i++) begin
      @(negedge clk);
      if (stale === 1'b1) begin
        rose = 1'b1;
        t_rise = cyc;
      end
    end
    vectors++; if (!rose) begin errors++; $display("FAIL timeout.rise got never exp after 1000 cycles"); end
    vectors++; if (rose && (t_rise - fv_cyc) !== 1000) begin errors++; $display("FAIL timeout.delay got %0d exp 1000", t_rise - fv_cyc); end
    @(posedge clk); #1;
    scan(P3, P6, P3, P3, 100);
    @(negedge clk);
    vectors++; if (fv_count - n0 !== 1) begin errors++; $display("FAIL timeout.resume_frames got %0d exp 1", fv_count - n0); end
    vectors++; if (fv_stale !== 1'b0 || stale !== 1'b0) begin errors++; $display("FAIL timeout.clear got %b/%b exp 0/0", fv_stale, stale); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int n0;
    drive(0, P3, 100);
    drive(1, P6, 100);
    drive(2, P3, 100);
    rst = 1'b1;
    digits_in = 4'b0111;
    segments_in = P3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (value !== 16'h0000 || blank !== 4'hF) begin errors++; $display("FAIL rst_mid.value_blank got %h/%h exp 0000/F", value, blank); end
    vectors++; if (invalid !== 4'h0 || dp !== 4'h0 || frame_valid !== 1'b0 || stale !== 1'b1) begin errors++; $display("FAIL rst_mid.flags got %h/%h/%b/%b exp 0/0/0/1", invalid, dp, frame_valid, stale); end
    n0 = fv_count;
    rst = 1'b0;
    @(posedge clk); #1;
    repeat (100) @(posedge clk);
    #1;
    drive(0, P1, 100);
    drive(1, P2, 100);
    @(negedge clk);
    vectors++; if (fv_count !== n0) begin errors++; $display("FAIL rst_mid.partial_frame got %0d exp 0", fv_count - n0); end
    @(posedge clk); #1;
    drive(2, P4, 100);
    @(negedge clk);
    vectors++; if (fv_count - n0 !== 1) begin errors++; $display("FAIL rst_mid.frames got %0d exp 1", fv_count - n0); end
    vectors++; if (value !== 16'h3421) begin errors++; $display("FAIL rst_mid.value got %h exp 3421", value); end
    vectors++; if (stale !== 1'b0 || blank !== 4'h0) begin errors++; $display("FAIL rst_mid.stale_blank got %b/%h exp 0/0", stale, blank); end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_blank_invalid;
    test_glitch;
    test_strobe_fault;
    test_timeout;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
